// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
//
// Purpose:
//   Two clients share a single 32-bit combinational ALU. Each client issues
//   one operation per valid/ready handshake. The arbiter picks a winner and
//   steers the winner's ctrl/operands onto the ALU. On accept it captures the
//   ALU result and zero flag into a one-entry response buffer. The buffered
//   value is then returned to the issuing client over its valid/ready
//   response channel.
//
// Parameters:
//   PRIO_FIXED    0 = round-robin on ties, 1 = requester 0 always wins ties
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/ready                request handshake for requester N
//   reqN_ctrl, reqN_a, reqN_b       ALU control code and operands from N
//   rspN_valid/ready                response handshake towards requester N
//   rsp_result, rsp_zero            buffered response, shared by both channels
//   alu_ctrl, alu_srcA, alu_srcB    drive to the shared ALU
//   alu_result, alu_zero            combinational return from the shared ALU

module alu_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,

  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  // Response buffer and arbitration history
  logic        buf_valid;
  logic        buf_owner;
  logic [31:0] buf_result;
  logic        buf_zero;
  logic        last_grant;

  logic        drain;
  logic        free;
  logic        grant_any;
  logic        grant_id;
  logic        accept;

  assign rsp0_valid = buf_valid & ~buf_owner;
  assign rsp1_valid = buf_valid &  buf_owner;
  assign rsp_result = buf_result;
  assign rsp_zero   = buf_zero;

  // The buffer can take a new result when empty, or when its current
  // content is being consumed on this very edge.
  assign drain = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
  assign free  = ~buf_valid | drain;

  // Winner selection. Depends only on the request valids and last_grant, so
  // the ALU drive below never sees rspN_ready combinationally.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = PRIO_FIXED ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // rst_n gates the combinational outputs so nothing is accepted and the
  // ALU is driven idle for the whole time reset is held.
  assign req0_ready = rst_n & free & grant_any & ~grant_id & req0_valid;
  assign req1_ready = rst_n & free & grant_any &  grant_id & req1_valid;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    alu_ctrl = 4'b0000;
    alu_srcA = 32'd0;
    alu_srcB = 32'd0;
    if (rst_n && grant_any) begin
      if (grant_id) begin
        alu_ctrl = req1_ctrl;
        alu_srcA = req1_a;
        alu_srcB = req1_b;
      end else begin
        alu_ctrl = req0_ctrl;
        alu_srcA = req0_a;
        alu_srcB = req0_b;
      end
    end
  end

  // last_grant moves only on a real accept; a grant stalled by a full
  // buffer does not count as a turn taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid  <= 1'b0;
      buf_owner  <= 1'b0;
      buf_result <= 32'd0;
      buf_zero   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      buf_valid  <= 1'b1;
      buf_owner  <= grant_id;
      buf_result <= alu_result;
      buf_zero   <= alu_zero;
      last_grant <= grant_id;
    end else if (drain) begin
      buf_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (round-robin and fixed-priority instances)

module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin instance
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_srcA, alu_srcB, alu_result;
  logic        alu_zero;

  // Fixed-priority instance
  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [3:0]  f_req0_ctrl, f_req1_ctrl;
  logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic        f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready;
  logic [31:0] f_rsp_result;
  logic        f_rsp_zero;
  logic [3:0]  f_alu_ctrl;
  logic [31:0] f_alu_srcA, f_alu_srcB, f_alu_result;
  logic        f_alu_zero;

  // Shared ALU stand-in
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_ctrl, alu_srcA, alu_srcB);
  assign alu_zero     = (alu_result == 32'd0);
  assign f_alu_result = alu_f(f_alu_ctrl, f_alu_srcA, f_alu_srcB);
  assign f_alu_zero   = (f_alu_result == 32'd0);

  alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_ctrl(alu_ctrl), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_ctrl(f_req0_ctrl), .req0_a(f_req0_a), .req0_b(f_req0_b),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_ctrl(f_req1_ctrl), .req1_a(f_req1_a), .req1_b(f_req1_b),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready),
    .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero),
    .alu_ctrl(f_alu_ctrl), .alu_srcA(f_alu_srcA), .alu_srcB(f_alu_srcB),
    .alu_result(f_alu_result), .alu_zero(f_alu_zero)
  );

  typedef struct packed {
    logic        owner;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t q[$];
  exp_t fq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic mon_pop(input bit fx, input logic owner, input logic [31:0] res, input logic z);
    exp_t e;
    if ((fx && fq.size() == 0) || (!fx && q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp: inst=%0d owner=%0d result=%0h, required no response", fx, owner, res);
      return;
    end
    e = fx ? fq.pop_front() : q.pop_front();
    check(fx ? "fx_rsp_owner" : "rsp_owner", 32'(owner), 32'(e.owner));
    check(fx ? "fx_rsp_result" : "rsp_result", res, e.res);
    check(fx ? "fx_rsp_zero" : "rsp_zero", 32'(z), 32'(e.zero));
  endtask

  // Monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (rsp0_valid && rsp1_valid) check("rsp_valid_onehot", 32'd1, 32'd0);
    if (rsp0_valid && rsp0_ready) mon_pop(1'b0, 1'b0, rsp_result, rsp_zero);
    if (rsp1_valid && rsp1_ready) mon_pop(1'b0, 1'b1, rsp_result, rsp_zero);
    if (f_rsp0_valid && f_rsp0_ready) mon_pop(1'b1, 1'b0, f_rsp_result, f_rsp_zero);
    if (f_rsp1_valid && f_rsp1_ready) mon_pop(1'b1, 1'b1, f_rsp_result, f_rsp_zero);
  end

  task automatic drive(input bit fx, input bit who, input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    if (!fx && !who) begin req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; end
    if (!fx &&  who) begin req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; end
    if ( fx && !who) begin f_req0_valid = v; f_req0_ctrl = c; f_req0_a = a; f_req0_b = b; end
    if ( fx &&  who) begin f_req1_valid = v; f_req1_ctrl = c; f_req1_a = a; f_req1_b = b; end
  endtask

  function automatic logic rdy(input bit fx, input bit who);
    if (fx) return who ? f_req1_ready : f_req0_ready;
    return who ? req1_ready : req0_ready;
  endfunction

  // Issue one op; returns #1 after the accepting edge with valid dropped
  task automatic send(input bit fx, input bit who, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    drive(fx, who, 1'b1, c, a, b);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdy(fx, who)) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    drive(fx, who, 1'b0, c, a, b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'b0010, 32'd1, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 4'b0010, 32'd2, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;

    // Reset: both valid, nothing may leak out
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_alu_srcA", alu_srcA, 32'd0);
    check("rst_alu_srcB", alu_srcB, 32'd0);

    // First tie after release goes to requester 0
    q.push_back('{1'b0, 32'd2, 1'b0});
    q.push_back('{1'b1, 32'd4, 1'b0});
    rst_n = 1'b1;
    #3;
    check("tie_req0_ready", 32'(req0_ready), 32'd1);
    check("tie_req1_ready", 32'(req1_ready), 32'd0);
    check("tie_alu_srcA", alu_srcA, 32'd1);
    fork
      send(1'b0, 1'b0, 4'b0010, 32'd1, 32'd1);
      send(1'b0, 1'b1, 4'b0010, 32'd2, 32'd2);
    join
    repeat (2) @(posedge clk);
    #1;

    // Single add
    q.push_back('{1'b0, 32'd12, 1'b0});
    send(1'b0, 1'b0, 4'b0010, 32'd5, 32'd7);
    check("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
    repeat (2) @(posedge clk);

    // Round-robin at full rate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q.push_back('{1'b0, 32'd0, 1'b1});
      q.push_back('{1'b1, 32'hFF, 1'b0});
    end
    @(posedge clk);
    #1;
    s = cyc;
    fork
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 4'b0110, 32'd3, 32'd3);
      for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 4'b0001, 32'hF0, 32'h0F);
    join
    check("rr_cycles", 32'(cyc - s), 32'd8);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: owner stalls, other requester must wait
    q.push_back('{1'b0, 32'd1, 1'b0});
    q.push_back('{1'b1, 32'd30, 1'b0});
    rsp0_ready = 1'b0;
    send(1'b0, 1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    fork
      send(1'b0, 1'b1, 4'b0010, 32'd10, 32'd20);
    join_none
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("bp_result", rsp_result, 32'd1);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_req1_accept", 32'(req1_ready), 32'd1);
    wait fork;
    repeat (2) @(posedge clk);

    // Fixed priority: requester 0 takes all three before requester 1
    do_reset();
    for (int i = 0; i < 3; i++) fq.push_back('{1'b0, 32'd3, 1'b0});
    for (int i = 0; i < 3; i++) fq.push_back('{1'b1, 32'd20, 1'b0});
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 4'b0010, 32'd1, 32'd2);
      for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 4'b0010, 32'd10, 32'd10);
    join
    repeat (2) @(posedge clk);
    #1;

    // Mid-op reset: buffered response is dropped, never delivered
    rsp1_ready = 1'b0;
    send(1'b0, 1'b1, 4'b0011, 32'hFFFF_0000, 32'hFFFF_0000);
    check("mid_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("mid_rsp_zero", 32'(rsp_zero), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_drop", 32'(rsp1_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(rsp1_valid), 32'd0);
    end

    check("q_empty", 32'(q.size()), 32'd0);
    check("fq_empty", 32'(fq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the single combinational 32-bit ALU between two clients, e.g. the main pipeline's execute stage and the packed-byte (add8/sat-add8) stream engine. Each client issues one operation per valid/ready handshake. The arbiter picks a winner, drives the shared ALU inputs, and captures result and zero flag in a one-entry response buffer. It then returns them to the issuing client over a valid/ready response channel.

## Interface
- PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- req0_ctrl / req1_ctrl  in  4  ALU control code, passed through unmodified
- req0_a, req0_b / req1_a, req1_b  in  32  operands (srcA, srcB)
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp_result  out  32  buffered result, shared by both response channels
- rsp_zero  out  1  buffered zero flag
- alu_ctrl  out  4  to shared ALU control
- alu_srcA, alu_srcB  out  32  to shared ALU operands
- alu_result  in  32  from shared ALU, combinational
- alu_zero  in  1  from shared ALU, combinational

## Operation
- State: buf_valid, buf_owner (0/1), buf_result[31:0], buf_zero, last_grant (0/1).
- Buffer free this cycle: free = !buf_valid | (rsp<buf_owner>_valid & rsp<buf_owner>_ready).
- Grant, combinational:
  - only req0_valid -> grant 0; only req1_valid -> grant 1;
  - both valid -> PRIO_FIXED ? 0 : !last_grant;
  - neither valid -> no grant.
- reqN_ready = free & (grant == N) & reqN_valid. The loser sees ready=0.
- reqN_ready depends combinationally on both req valids. A requester must not derive valid from ready, and must hold valid, ctrl, a and b stable until accepted.
- ALU drive:
  - on grant, alu_ctrl/srcA/srcB = winner's ctrl/a/b;
  - otherwise alu_ctrl = 4'b0000 and operands = 0.
- On accept (some reqN_valid & reqN_ready):
  - buf_result <= alu_result, buf_zero <= alu_zero;
  - buf_owner <= N, buf_valid <= 1, last_grant <= N.
- On drain without a new accept: buf_valid <= 0. buf_result and buf_zero keep their last value.
- rspN_valid = buf_valid & (buf_owner == N). At most one rsp valid at any time.
- rsp_result and rsp_zero are meaningful only while some rspN_valid = 1.
- Undefined ctrl codes are passed to the ALU as-is. The arbiter does no decoding.
- last_grant updates only on an actual accept, not on a grant that stalls on a full buffer.

## Timing
- Reset values: buf_valid=0, buf_owner=0, buf_result=0, buf_zero=0, last_grant=1 (requester 0 wins the first tie).
  - All rsp valids 0, all req readies 0 while rst_n low.
  - ALU outputs 0 while rst_n low.
- Latency: accept in cycle T -> rspN_valid=1 from cycle T+1.
- Throughput: one op per cycle when the owner holds rspN_ready=1 (drain and accept in the same cycle).
- Full buffer and owner not ready: all req readies 0, buffer held unchanged. No loss, no overwrite.
- Simultaneous drain + accept: the new result replaces the old one. buf_valid stays 1 and buf_owner may switch owner in the same edge.
- Requester 1 may be accepted while requester 0's response drains. rsp0_valid falls and rsp1_valid rises on the same edge.
- Reset asserted mid-operation: any buffered response is discarded immediately, with no completion. After release, all state restarts from the reset values.
- No combinational path from rspN_ready to alu_* outputs, other than through req readies.

## Test plan
- Reset check: hold rst_n=0 with both req valid -> both readies 0, both rsp valids 0, alu_ctrl=0. Release rst_n -> first tie grants requester 0.
- Single add: req0 ctrl=0010, a=5, b=7 -> accepted cycle T; rsp0_valid at T+1 with rsp_result=12, rsp_zero=0; rsp1_valid stays 0.
- Round-robin: both requesters valid every cycle, rsp readies held 1, req0 does sub 3-3, req1 does or 0xF0|0x0F.
  - Grants alternate 0,1,0,1 at one op per cycle.
  - req0 results 0 with zero=1; req1 results 0xFF with zero=0.
- Backpressure: req0 slt -1<1 accepted, rsp0_ready=0 for 4 cycles, req1 waiting.
  - rsp0_valid and result=1 held stable for 4 cycles; req1_ready=0 throughout.
  - req1 is accepted on the cycle rsp0_ready goes to 1.
- PRIO_FIXED=1: both valid for 3 ops each -> requester 0 is granted all 3 ops before requester 1 gets any.
- Mid-op reset: accept req1 xor 0xFFFF0000^0xFFFF0000, assert rst_n low before rsp1_ready -> rsp1_valid drops asynchronously and no response is delivered after release.
